// File: rtl/rr_push_scheduler.sv
// rr_push_scheduler
// Round-robin scheduler that maps up to INPUT_PORTS valid producers onto
// OUTPUT_PORTS FIFO push ports in a single cycle. The k-th valid producer in
// rotating scan order (starting at ptr) is paired with the k-th output whose
// ready_in is high. The grant is purely combinational; the only arbitration
// state is ptr.
//
// Optional build macro RR_PUSH_STATS_EN: when defined, stall_cnt counts the
// cycles in which some producer is valid but nothing is pushed, saturating at
// 16'hFFFF. When undefined, stall_cnt is tied to zero and no counter exists.
module rr_push_scheduler #(
  parameter int INPUT_PORTS  = 4,
  parameter int OUTPUT_PORTS = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [INPUT_PORTS-1:0]             valid_in,
  input  logic [INPUT_PORTS*DATA_WIDTH-1:0]  data_in,
  output logic [INPUT_PORTS-1:0]             ready_out,
  output logic [OUTPUT_PORTS-1:0]            push,
  input  logic [OUTPUT_PORTS-1:0]            ready_in,
  output logic [OUTPUT_PORTS*DATA_WIDTH-1:0] data_out,
  output logic [15:0]                        stall_cnt
);

  localparam int PTR_W = $clog2(INPUT_PORTS);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             xfer;

  // Grant logic: pair valid producers in scan order with ready outputs in
  // ascending order, and work out where the pointer goes next.
  always_comb begin : arbitrate
    int out_rank [OUTPUT_PORTS];
    int n_ready;
    int vcnt;
    int idx;
    int last_idx;
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would make synthesis infer a latch.
    push      = '0;
    data_out  = '0;
    ready_out = '0;
    xfer      = 1'b0;
    ptr_nxt   = ptr;
    n_ready   = 0;
    vcnt      = 0;
    idx       = 0;
    last_idx  = 0;

    // Rank of each output among the ready ones; unready outputs never match.
    for (int j = 0; j < OUTPUT_PORTS; j++) begin
      out_rank[j] = n_ready;
      if (ready_in[j]) n_ready = n_ready + 1;
    end

    // Reset forces every output low even between clock edges.
    if (rst_n) begin
      for (int k = 0; k < INPUT_PORTS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= INPUT_PORTS) idx = idx - INPUT_PORTS;
        if (valid_in[idx] && (vcnt < n_ready)) begin
          for (int j = 0; j < OUTPUT_PORTS; j++) begin
            if (ready_in[j] && (out_rank[j] == vcnt)) begin
              push[j] = 1'b1;
              data_out[j*DATA_WIDTH +: DATA_WIDTH] = data_in[idx*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          ready_out[idx] = 1'b1;
          xfer           = 1'b1;
          last_idx       = idx;
          vcnt           = vcnt + 1;
        end
      end
      // Explicit wrap so non-power-of-two port counts have no dead value.
      if (xfer) begin
        ptr_nxt = (last_idx == INPUT_PORTS - 1) ? '0 : PTR_W'(last_idx + 1);
      end
    end
  end

  // Priority pointer: advances past the last accepted producer, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= ptr_nxt;
    end
  end

`ifdef RR_PUSH_STATS_EN
  logic [15:0] stall_q;

  // Stall counter: a producer waits but nothing is pushed; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((|valid_in) && (push == '0) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_push_scheduler.sv
// tb_rr_push_scheduler
// Scoreboard bench: the driver computes the expected response of each cycle
// from a queue-based reference model and pushes it; a monitor pops and
// compares on the falling edge. Honors RR_PUSH_STATS_EN like the design.
module tb_rr_push_scheduler;

  localparam int NI = 4;
  localparam int NO = 2;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NI-1:0]     valid_in;
  logic [NI*DW-1:0]  data_in;
  logic [NI-1:0]     ready_out;
  logic [NO-1:0]     push;
  logic [NO-1:0]     ready_in;
  logic [NO*DW-1:0]  data_out;
  logic [15:0]       stall_cnt;

  rr_push_scheduler #(.INPUT_PORTS(NI), .OUTPUT_PORTS(NO), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .push      (push),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NO-1:0]    push;
    logic [NI-1:0]    ready;
    logic [NO*DW-1:0] data;
    logic [15:0]      stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr   = 0;
  int   m_stall = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One arbitration cycle: apply stimulus, predict the response, advance model.
  task automatic drive(input logic [NI-1:0] v, input logic [NO-1:0] r);
    int   vq[$];
    int   rq[$];
    int   pairs;
    exp_t e;
    logic [DW-1:0] pay [NI];
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) pay[i] = $urandom;
    valid_in = v;
    ready_in = r;
    for (int i = 0; i < NI; i++) data_in[i*DW +: DW] = pay[i];

    for (int k = 0; k < NI; k++) if (v[(m_ptr + k) % NI]) vq.push_back((m_ptr + k) % NI);
    for (int j = 0; j < NO; j++) if (r[j]) rq.push_back(j);
    pairs = (vq.size() < rq.size()) ? vq.size() : rq.size();

    e.push  = '0;
    e.ready = '0;
    e.data  = '0;
    e.stall = 16'(m_stall);
    for (int m = 0; m < pairs; m++) begin
      e.push[rq[m]]            = 1'b1;
      e.ready[vq[m]]           = 1'b1;
      e.data[rq[m]*DW +: DW]   = pay[vq[m]];
    end
    exp_q.push_back(e);

    if (pairs > 0) m_ptr = (vq[pairs-1] + 1) % NI;
`ifdef RR_PUSH_STATS_EN
    if ((v != '0) && (pairs == 0) && (m_stall < 65535)) m_stall++;
`endif
  endtask

  // Monitor: compare the live combinational response mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("push",      push,      e.push);
      check("ready_out", ready_out, e.ready);
      check("data_out",  data_out,  e.data);
      check("stall_cnt", stall_cnt, e.stall);
    end
  end

  initial begin
    int budget;
    rst_n    = 1'b0;
    valid_in = '1;
    ready_in = '1;
    for (int i = 0; i < NI; i++) data_in[i*DW +: DW] = $urandom;

    // Outputs held low during reset even with live requests.
    #12;
    check("rst_push",  push,      '0);
    check("rst_ready", ready_out, '0);
    check("rst_data",  data_out,  '0);
    check("rst_stall", stall_cnt, '0);
    valid_in = '0;
    ready_in = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // All valid, both outputs ready: 0,1 then 2,3 then 0,1.
    repeat (3) drive(4'b1111, 2'b11);
    // ptr=2, sparse valid: out0<-in3, out1<-in0, next ptr 1.
    drive(4'b1001, 2'b11);
    // Move to ptr 0, then only output 1 ready.
    drive(4'b1000, 2'b01);
    drive(4'b1111, 2'b10);
    // Move to ptr 3, then five cycles with no ready output.
    drive(4'b0100, 2'b01);
    repeat (5) drive(4'b1111, 2'b00);
    drive(4'b0000, 2'b00);

    // Mid-cycle reset with ptr=3: grant visible, then cleared at once.
    @(negedge clk);
    #1;
    valid_in = 4'b1111;
    ready_in = 2'b11;
    #1;
    check("pre_rst_ready", ready_out, 4'b1001);
    rst_n = 1'b0;
    #1;
    check("mid_rst_push",  push,      '0);
    check("mid_rst_ready", ready_out, '0);
    check("mid_rst_data",  data_out,  '0);
    valid_in = '0;
    ready_in = '0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_stall", stall_cnt, '0);
    rst_n   = 1'b1;
    m_ptr   = 0;
    m_stall = 0;
    // First grant after release must start from input 0.
    drive(4'b1111, 2'b01);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom), 2'($urandom));
    end

`ifdef RR_PUSH_STATS_EN
    // Long stall drives the counter into saturation.
    repeat (70000) drive(4'b1111, 2'b00);
    drive(4'b0000, 2'b00);
    drive(4'b0000, 2'b00);
`else
    repeat (50) drive(4'b1111, 2'b00);
    drive(4'b0000, 2'b00);
`endif

    budget = 20;
    while ((exp_q.size() > 0) && (budget > 0)) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
    end

`ifdef RR_PUSH_STATS_EN
    check("stall_sat", stall_cnt, 16'hFFFF);
`else
    check("stall_tied", stall_cnt, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_push_scheduler.md
RR_PUSH_SCHEDULER -- requirements
Module: rr_push_scheduler

Interface
REQ-001 SHALL have parameter INPUT_PORTS, default 4, number of requesting producers (>=2).
REQ-002 SHALL have parameter OUTPUT_PORTS, default 2, number of FIFO push ports (1..INPUT_PORTS).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, payload width per port.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port valid_in  input  INPUT_PORTS  per-producer request.
REQ-007 SHALL have port data_in  input  INPUT_PORTS x DATA_WIDTH  per-producer payload.
REQ-008 SHALL have port ready_out  output  INPUT_PORTS  per-producer accept; transfer when valid_in[i] & ready_out[i].
REQ-009 SHALL have port push  output  OUTPUT_PORTS  per-FIFO write strobe.
REQ-010 SHALL have port ready_in  input  OUTPUT_PORTS  per-FIFO not-full.
REQ-011 SHALL have port data_out  output  OUTPUT_PORTS x DATA_WIDTH  per-FIFO write payload.
REQ-012 SHALL have port stall_cnt  output  16  saturating stall-cycle count (see Configuration).

Function
REQ-013 SHALL hold a priority pointer ptr of clog2(INPUT_PORTS) bits, the only arbitration state.
REQ-014 SHALL scan inputs in rotating order ptr, ptr+1, ..., ptr+INPUT_PORTS-1 (mod INPUT_PORTS).
REQ-015 SHALL assign the k-th valid input in scan order to the k-th output port with ready_in high, output ports taken in ascending index; outputs with ready_in low are skipped, never assigned.
REQ-016 SHALL stop assigning once all ready outputs are used; surplus valid inputs get ready_out=0.
REQ-017 SHALL drive push[j]=1 and data_out[j]=assigned payload for assigned outputs; push[j]=0 and data_out[j]=0 otherwise.
REQ-018 SHALL drive ready_out[i]=1 exactly for assigned inputs; ready_out SHALL not depend on valid_in[i] of that input being low (ready_out[i]=0 when valid_in[i]=0).
REQ-019 SHALL have zero-cycle latency: push/data_out/ready_out are combinational from the current cycle's inputs and ptr.
REQ-020 SHALL update ptr on clk rising edge to (index of last input accepted in scan order + 1) mod INPUT_PORTS when at least one transfer occurred.
REQ-021 SHALL hold ptr unchanged in cycles with no transfer (no valid, or no ready output).
REQ-022 SHALL guarantee every continuously valid input is accepted within ceil(INPUT_PORTS/1) cycles in which at least one output is ready.
REQ-023 SHALL wrap ptr from INPUT_PORTS-1 to 0 with no dead value for non-power-of-two INPUT_PORTS.

Reset
REQ-024 SHALL, while rst_n is low, force ptr=0, stall_cnt=0, push=0, ready_out=0, data_out=0, regardless of clk.
REQ-025 SHALL resume arbitration from ptr=0 on the first rising clk edge after rst_n deasserts; reset mid-operation discards no stored payload (none is stored).

Configuration
REQ-026 SHALL, with macro RR_PUSH_STATS_EN defined, increment stall_cnt each cycle where |valid_in=1 and push=0, saturating at 16'hFFFF, cleared only by reset.
REQ-027 SHALL, without RR_PUSH_STATS_EN, tie stall_cnt to 0 and contain no counter register; arbitration behaviour identical in both builds.

Verification (INPUT_PORTS=4, OUTPUT_PORTS=2, DATA_WIDTH=32)
REQ-028 SHALL cover: reset, valid_in=4'b1111, ready_in=2'b11 held -> cycle0 accepts inputs 0,1 (data_out[0]=data_in[0], data_out[1]=data_in[1]); cycle1 accepts 2,3; cycle2 accepts 0,1.
REQ-029 SHALL cover: ptr=0, valid_in=4'b1111, ready_in=2'b10 -> push=2'b10, data_out[1]=data_in[0], data_out[0]=0, ready_out=4'b0001, next ptr=1.
REQ-030 SHALL cover: ptr=2, valid_in=4'b1001, ready_in=2'b11 -> output0=input3, output1=input0, ready_out=4'b1001, next ptr=1.
REQ-031 SHALL cover: ptr=3, valid_in=4'b1111, ready_in=2'b00 for 5 cycles -> push=0, ready_out=0, ptr stays 3; with RR_PUSH_STATS_EN stall_cnt rises by 5.
REQ-032 SHALL cover: ptr=3 then rst_n low mid-cycle (no clk edge) -> push, ready_out, data_out immediately 0; after release first grant starts at input 0.
REQ-033 SHALL cover: RR_PUSH_STATS_EN, stall forced 70000 cycles -> stall_cnt=16'hFFFF and holds; build without macro -> stall_cnt=0 throughout.
